// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive/transmit path.
// The parity feature of the receiver is enabled with UART_RX_PARITY_EN.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } uart_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, phase reset by clr.
// Shared by the UART receiver and transmitter.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_frontend.sv
// Oversampling UART receiver (8N1, LSB first) with valid/ready byte output.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 16_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [SW-1:0] S_LO   = SW'(M - 1);
    localparam logic [SW-1:0] S_MID  = SW'(M);
    localparam logic [SW-1:0] S_HI   = SW'(M + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    if (DIV < 1) begin : g_div_check
        $error("uart_rx_frontend: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 1");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_check
        $error("uart_rx_frontend: OVERSAMPLE must be even and at least 8");
    end

    logic                 rx_meta, rxs, rxs_d;
    uart_state_t          state;
    logic [SW-1:0]        s_cnt;
    logic [BW-1:0]        bit_idx;
    logic [1:0]           votes;
    logic [DATA_BITS-1:0] shreg;
    logic                 tick, start_edge, bit_val, sample_pt, bit_end;
`ifdef UART_RX_PARITY_EN
    logic                 parity_ok;
`endif

    // Two-flop synchroniser; reset to the idle (high) line level so release never fakes a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    assign start_edge = (state == IDLE) && rxs_d && !rxs;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_edge),
        .tick  (tick)
    );

    // Third vote is the live sample taken at M+1, so the decision needs no extra cycle.
    assign bit_val   = maj3(votes[0], votes[1], rxs);
    assign sample_pt = tick && (s_cnt == S_HI);
    assign bit_end   = tick && (s_cnt == S_LAST);
    assign busy      = (state != IDLE);

    // NOTE: all state and outputs update with <= so every branch below sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            s_cnt     <= '0;
            bit_idx   <= '0;
            votes     <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_ok <= 1'b1;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (tick && state != IDLE) begin
                s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + SW'(1);
                if (s_cnt == S_LO)  votes[0] <= rxs;
                if (s_cnt == S_MID) votes[1] <= rxs;
            end

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state <= START;
                        s_cnt <= '0;
                    end
                end
                START: begin
                    if (sample_pt && bit_val) begin
                        state <= IDLE;
                    end else if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (sample_pt) begin
                        shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                    end
                    if (bit_end) begin
                        if (bit_idx == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (sample_pt) begin
                        parity_ok <= ~(^shreg ^ bit_val);
                    end
                    if (bit_end) begin
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (sample_pt) begin
                        if (!bit_val) begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end else begin
                            state <= IDLE;
`ifdef UART_RX_PARITY_EN
                            if (!parity_ok) begin
                                frame_err <= 1'b1;
                            end else
`endif
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboard bench for uart_rx_frontend at 16 clocks per bit (DIV=1).
// Follows UART_RX_PARITY_EN to send and check the parity bit.
module tb_uart_rx_frontend;

    localparam int OS       = 16;
    localparam int BIT_CLKS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_NOM  = 2 + (10 * OS + OS / 2 + 1) + 1;
`else
    localparam int LAT_NOM  = 2 + (9 * OS + OS / 2 + 1) + 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, start_cyc = 0, rise_cyc = 0, lat = 0;
    int ferr_cnt = 0, ovr_cnt = 0, both_cnt = 0;
    int exp_ferr = 0, exp_ovr = 0;
    logic prev_valid = 1'b0;
    logic [7:0] exp_q[$];
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx_frontend #(
        .CLK_FREQ   (16_000_000),
        .BAUD       (1_000_000),
        .OVERSAMPLE (OS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Output monitor: samples on the falling edge and pops the scoreboard on each handshake.
    initial forever begin
        @(negedge clk);
        if (rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = rx_valid;
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (frame_err && overrun) both_cnt++;
        if (rx_valid && rx_ready) begin
            check("byte_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("rx_data", rx_data, exp_q.pop_front());
        end
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        start_cyc = cyc;
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) hold(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
        hold((^d) ^ par_flip, BIT_CLKS);
`endif
        hold(stop_bit, BIT_CLKS);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        hold(1'b1, 8);

        // 1: single byte, consumer always ready
        rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        lat = rise_cyc - start_cyc;
        check("latency_in_window", 32'(lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1), 1);
        check("t1_valid_dropped", rx_valid, 0);
        check("t1_q_empty", exp_q.size(), 0);
        check("t1_frame_err", ferr_cnt, exp_ferr);
        check("t1_overrun", ovr_cnt, exp_ovr);
        hold(1'b1, 10);

        // 2: back-to-back frames with consumer stalled
        rx_ready = 1'b0;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        exp_ovr++;
        hold(1'b1, 4);
        check("t2_overrun", ovr_cnt, exp_ovr);
        check("t2_valid_held", rx_valid, 1);
        check("t2_data_held", rx_data, 8'h3C);
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        @(negedge clk);
        check("t2_valid_cleared", rx_valid, 0);
        check("t2_q_empty", exp_q.size(), 0);
        @(posedge clk);
        #1 rx_ready = 1'b1;

        // 3: short glitch on the line
        hold(1'b0, 4);
        hold(1'b1, 30);
        check("t3_busy", busy, 0);
        check("t3_rx_valid", rx_valid, 0);
        check("t3_frame_err", ferr_cnt, exp_ferr);

        // 4: stop bit low followed by a break, then a good frame
        send_frame(8'h55, 1'b0);
        exp_ferr++;
        hold(1'b0, 40);
        check("t4_busy_in_break", busy, 1);
        hold(1'b1, 20);
        check("t4_frame_err", ferr_cnt, exp_ferr);
        check("t4_no_valid", rx_valid, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        hold(1'b1, 10);
        check("t4_q_empty", exp_q.size(), 0);
        check("t4_overrun", ovr_cnt, exp_ovr);

        // 5: reset during bit 3 of 0xF8 (bits 3..7 high, so the tail has no falling edge)
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) hold(1'b0, BIT_CLKS);
        hold(1'b1, 5);
        check("t5_busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_rx_valid", rx_valid, 0);
        check("t5_rst_rx_data", rx_data, 8'h00);
        check("t5_rst_frame_err", frame_err, 0);
        check("t5_rst_overrun", overrun, 0);
        check("t5_rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        hold(1'b1, BIT_CLKS * 7);
        check("t5_tail_frame_err", ferr_cnt, exp_ferr);
        check("t5_tail_no_valid", rx_valid, 0);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        hold(1'b1, 10);
        check("t5_q_empty", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
        // 6: good parity, then bad parity
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        hold(1'b1, 10);
        check("t6_good_q_empty", exp_q.size(), 0);
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        exp_ferr++;
        hold(1'b1, 10);
        check("t6_bad_frame_err", ferr_cnt, exp_ferr);
        check("t6_bad_no_valid", rx_valid, 0);
`endif

        check("final_q_empty", exp_q.size(), 0);
        check("final_frame_err", ferr_cnt, exp_ferr);
        check("final_overrun", ovr_cnt, exp_ovr);
        check("flags_never_together", both_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
